// File: rtl/key_step_conditioner.sv
// key_step_conditioner: turns one raw, bouncing, active-low pushbutton into
// a debounced level plus single-cycle press, release and step strobes.
// The step strobe also carries optional hold-to-repeat pulses.
// Datapath: 2-flop synchroniser -> debounce FSM -> repeat timer.
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_n,
  input  logic rep_en,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  // rep_armed: 0 while waiting for the first repeat (REPEAT_DELAY),
  // 1 once repeats run at REPEAT_PERIOD.
  logic             rep_armed_q, rep_armed_d;
  logic             key_level_q, key_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  logic [REP_W-1:0] rep_limit_s;

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

  // Next-state and next-output computation for synchroniser, debounce FSM and repeat timer.
  always_comb begin
    s1_d        = key_n;
    s2_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    step_d      = 1'b0;
    rep_limit_s = rep_armed_q ? PER_LAST : DLY_LAST;

    case (state_q)
      ST_IDLE: begin
        if (!s2_q) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_CHK: begin
        if (s2_q) begin
          // Bounce: key went back up before the debounce window closed.
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_HELD;
          key_level_d = 1'b1;
          press_d     = 1'b1;
          step_d      = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (s2_q) begin
          // Leaving for release check: repeat timer is frozen, no repeat.
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end else if (!rep_en) begin
          // Disabled repeat restarts the full delay once re-enabled.
          rep_cnt_d   = '0;
          rep_armed_d = 1'b0;
        end else if (rep_cnt_q == rep_limit_s) begin
          step_d      = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      ST_RELEASE_CHK: begin
        if (!s2_q) begin
          // Release glitch: resume holding with the repeat timer untouched.
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_IDLE;
          key_level_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        key_level_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered-output flops; reset forces the released, idle condition.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
    end
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Self-checking bench for key_step_conditioner with short debounce/repeat
// parameters. Expected pulses (cycle + kind) are queued when stimulus is
// driven; a negedge monitor pops and compares each pulse the DUT emits.
module tb_key_step_conditioner;

  logic clk;
  logic rst_n;
  logic key_n;
  logic rep_en;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // kind bits: {press, release, step}
  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;

  exp_t exp_q[$];

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (rst_n),
    .key_n        (key_n),
    .rep_en       (rep_en),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge N (and before the next one) cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [2:0] k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_level"},   int'(key_level),     0);
    check_val({tag, "_press"},   int'(press_pulse),   0);
    check_val({tag, "_release"}, int'(release_pulse), 0);
    check_val({tag, "_step"},    int'(step_pulse),    0);
  endtask

  // Monitor: every observed pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [2:0] k;
    exp_t       e;
    k = {press_pulse, release_pulse, step_pulse};
    if (k != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pulse", int'(k), 0);
      end else begin
        e = exp_q.pop_front();
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_kind", int'(k), int'(e.kind));
      end
    end
  end

  initial begin
    int e0;
    int r0;
    rst_n  = 1'b0;
    key_n  = 1'b1;
    rep_en = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(4);

    // Clean press with repeat disabled, then clean release.
    e0 = cyc + 1;
    key_n = 1'b0;
    push_exp(e0 + 6, 3'b101);
    wait_until(e0 + 5);
    check_val("press_level_before", int'(key_level), 0);
    tick(1);
    check_val("press_level_after", int'(key_level), 1);
    wait_until(e0 + 26);
    r0 = cyc + 1;
    key_n = 1'b1;
    push_exp(r0 + 6, 3'b010);
    wait_until(r0 + 5);
    check_val("release_level_before", int'(key_level), 1);
    tick(1);
    check_val("release_level_after", int'(key_level), 0);
    tick(4);
    check_val("clean_q_empty", exp_q.size(), 0);

    // Bounce rejection: low 3, high 1, low 3, high.
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(3);
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_val("bounce_level", int'(key_level), 0);
    end
    check_val("bounce_q_empty", exp_q.size(), 0);

    // Auto-repeat while held for 40 cycles.
    rep_en = 1'b1;
    tick(1);
    e0 = cyc + 1;
    key_n = 1'b0;
    push_exp(e0 + 6, 3'b101);
    for (int k = 16; k <= 41; k += 5) push_exp(e0 + k, 3'b001);
    push_exp(e0 + 46, 3'b010);
    wait_until(e0 + 39);
    key_n = 1'b1;
    wait_until(e0 + 50);
    rep_en = 1'b0;
    check_val("repeat_q_empty", exp_q.size(), 0);

    // Release glitch keeps HELD, then a clean release.
    e0 = cyc + 1;
    key_n = 1'b0;
    push_exp(e0 + 6, 3'b101);
    wait_until(e0 + 10);
    key_n = 1'b1; tick(2);
    key_n = 1'b0;
    tick(10);
    check_val("glitch_level_held", int'(key_level), 1);
    r0 = cyc + 1;
    key_n = 1'b1;
    push_exp(r0 + 6, 3'b010);
    wait_until(r0 + 5);
    check_val("glitch_rel_level_before", int'(key_level), 1);
    tick(1);
    check_val("glitch_rel_level_after", int'(key_level), 0);
    tick(4);
    check_val("glitch_q_empty", exp_q.size(), 0);

    // Reset during PRESS_CHK, fresh full-latency press, reset mid-repeat.
    rep_en = 1'b1;
    key_n  = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #2;
    check_outputs_zero("rst_presschk");
    tick(2);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_exp(e0 + 6, 3'b101);
    push_exp(e0 + 16, 3'b001);
    wait_until(e0 + 5);
    check_val("rst_fresh_level_before", int'(key_level), 0);
    wait_until(e0 + 18);
    check_val("rst_held_level", int'(key_level), 1);
    rst_n = 1'b0;
    #2;
    check_outputs_zero("rst_held");
    key_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check_val("rst_q_empty", exp_q.size(), 0);

    // rep_en toggled low mid-hold restarts the repeat delay.
    rep_en = 1'b1;
    e0 = cyc + 1;
    key_n = 1'b0;
    push_exp(e0 + 6, 3'b101);
    push_exp(e0 + 16, 3'b001);
    push_exp(e0 + 30, 3'b001);
    push_exp(e0 + 35, 3'b001);
    push_exp(e0 + 43, 3'b010);
    wait_until(e0 + 17);
    rep_en = 1'b0;
    wait_until(e0 + 20);
    rep_en = 1'b1;
    wait_until(e0 + 36);
    key_n = 1'b1;
    wait_until(e0 + 50);
    check_val("toggle_level_final", int'(key_level), 0);
    check_val("toggle_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
- Conditions one raw, active-low DE-board pushbutton into clean single-clock strobes for the step counter and the display mux.
- Stages: 2-flop synchroniser, debounce state machine, optional hold-to-repeat generator.
- Sits directly upstream of the 4-bit step counter. Its step_pulse replaces the raw key as the counter advance, so the counter runs in the CLOCK_50 domain instead of being clocked by the bouncing key.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised key must stay stable to accept an edge (20 ms at 50 MHz); legal range >= 2.
- REPEAT_DELAY, 25000000, cycles from press_pulse to the first auto-repeat pulse (0.5 s); >= 2.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (0.1 s); >= 2.

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw pushbutton, 0 = pressed, asynchronous and bouncing.
- rep_en  in  1  1 = auto-repeat enabled while held (synchronous).
- key_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on each accepted press.
- release_pulse  out  1  one-cycle strobe on each accepted release.
- step_pulse  out  1  press_pulse OR repeat strobe; feeds the step counter.

Behaviour:
- Reset (async assert, sync release):
  - sync flops = 1 (released); state = IDLE; all counters = 0.
  - key_level, press_pulse, release_pulse, step_pulse = 0.
  - Asserting reset mid-press or mid-repeat aborts immediately with no pulses.
- Synchroniser: s1 <= key_n, s2 <= s1; the FSM uses only s2. Counter widths are $clog2 of the parameter; all outputs are registered.
- States:
  - IDLE, s2 = 0: go to PRESS_CHK, cnt = 0.
  - PRESS_CHK:
    - s2 = 1: back to IDLE, no pulse (bounce rejected).
    - s2 = 0 and cnt = DEBOUNCE_CYCLES-1: go to HELD; key_level <= 1; press_pulse and step_pulse high for exactly one cycle; rep_cnt = 0.
    - Otherwise cnt++.
  - HELD, s2 = 1: go to RELEASE_CHK, cnt = 0.
  - RELEASE_CHK:
    - s2 = 0: back to HELD, no pulse; rep_cnt frozen, not cleared.
    - s2 = 1 and cnt = DEBOUNCE_CYCLES-1: go to IDLE; key_level <= 0; release_pulse high for one cycle.
    - Otherwise cnt++.
- Latency: if edge E0 is the first to sample key_n = 0 and the key then stays low, press_pulse rises at E0+DEBOUNCE_CYCLES+2 and falls one edge later. Release is symmetric.
- Repeat:
  - Active only in HELD with rep_en = 1; rep_cnt increments each such cycle.
  - First repeat at press edge P + REPEAT_DELAY, then every REPEAT_PERIOD.
  - Each repeat is a one-cycle step_pulse; press_pulse does not fire on repeats.
  - rep_en = 0 clears rep_cnt and suppresses repeats. rep_en rising mid-hold restarts the REPEAT_DELAY timing from that cycle.
  - No repeat is ever emitted in RELEASE_CHK or IDLE.
- Never asserted simultaneously:
  - press_pulse and release_pulse.
  - Two step_pulses in adjacent cycles.

Test Plan (overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press:
  - key_n 1->0 sampled at E0, held -> press_pulse and step_pulse high only in cycle E0+6..E0+7.
  - key_level = 1 from E0+6.
  - rep_en = 0, so no further step_pulse.
- Bounce rejection: key_n low 3 cycles, high 1, low 3, then high -> no press_pulse, key_level stays 0.
- Auto-repeat:
  - rep_en = 1, key held 40 cycles after E0 -> step_pulse at E0+6, E0+16, E0+21, E0+26, E0+31, E0+36 ...
  - press_pulse only at E0+6.
- Release with glitch:
  - From HELD, key_n high 2 cycles then low -> remains HELD, no release_pulse.
  - A clean high sampled at R0 -> release_pulse at R0+6; key_level = 0 from R0+6.
- Reset mid-operation: reset_n low during PRESS_CHK or HELD -> all outputs 0 asynchronously; after release, key held low gives a fresh press at full latency.
- rep_en toggle: rep_en 1->0 at E0+18, back to 1 at E0+20 -> no repeat at E0+21; next step_pulse at E0+30.
